// File: rtl/lpc_record_framer.sv
// lpc_record_framer: snapshots completed LPC cycles into records, buffers
// them in a small FIFO and streams each record as bytes over valid/ready.
// Optional macro LPC_RECORD_FRAMER_CHECKSUM_EN appends an XOR checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no record in flight; out_valid low, waiting for FIFO data
// ST_SEND | presenting byte idx of the shadow record; out_valid high
module lpc_record_framer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_BYTES = 2
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  in_cyctype_dir,
   input  logic [31:0] in_addr,
   input  logic [7:0]  in_data,
   input  logic        in_sync_timeout,
   input  logic        in_clock_enable,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow,
   output logic [7:0]  drop_count
);

   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int AW_BITS = 8 * ADDR_BYTES;
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
   localparam int REC_LEN = ADDR_BYTES + 3;
`else
   localparam int REC_LEN = ADDR_BYTES + 2;
`endif
   localparam int IDX_W = $clog2(REC_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

   typedef struct packed {
      logic [3:0]         cyctype_dir;
      logic [AW_BITS-1:0] addr;
      logic [7:0]         data;
      logic               sync_timeout;
      logic               lost;
   } rec_t;

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   function automatic logic [7:0] head_byte(input rec_t r);
      return {r.cyctype_dir, 2'b00, r.lost, r.sync_timeout};
   endfunction

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   rec_t                    shadow_q, shadow_d;
   logic [7:0]              out_byte_q, out_byte_d;
   logic                    out_valid_q, out_valid_d;
   logic                    prev_ce_q, prev_ce_d;
   logic                    lost_q, lost_d;
   logic                    overflow_q, overflow_d;
   logic [7:0]              drop_count_q, drop_count_d;
   logic [PW:0]             wr_ptr_q, wr_ptr_d;
   logic [PW:0]             rd_ptr_q, rd_ptr_d;
   rec_t                    fifo_mem_q [FIFO_DEPTH];

   logic                    fifo_full, fifo_empty;
   logic                    strobe, pop, wr_ok, drop;
   rec_t                    fifo_head, wr_rec;
   logic [IDX_W-1:0]        idx_inc;
   logic [REC_LEN-1:0][7:0] frame_bytes;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign fifo_head  = fifo_mem_q[rd_ptr_q[PW-1:0]];
   assign idx_inc    = idx_q + IDX_W'(1);

   // Byte view of the record currently held in the shadow register
   always_comb begin
      frame_bytes    = '0;
      frame_bytes[0] = head_byte(shadow_q);
      for (int i = 0; i < ADDR_BYTES; i++)
         frame_bytes[1 + i] = shadow_q.addr[8 * (ADDR_BYTES - 1 - i) +: 8];
      frame_bytes[ADDR_BYTES + 1] = shadow_q.data;
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
      frame_bytes[ADDR_BYTES + 2] = 8'h00;
      for (int i = 0; i < ADDR_BYTES + 2; i++)
         frame_bytes[ADDR_BYTES + 2] = frame_bytes[ADDR_BYTES + 2] ^ frame_bytes[i];
`endif
   end

   // Serializer next-state: pops the FIFO and walks the shadow record byte by byte
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      out_byte_d  = out_byte_q;
      out_valid_d = out_valid_q;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               shadow_d    = fifo_head;
               out_byte_d  = head_byte(fifo_head);
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               if (idx_q != LAST_IDX) begin
                  idx_d      = idx_inc;
                  out_byte_d = frame_bytes[idx_inc];
               end else if (!fifo_empty) begin
                  // back-to-back: next record's header follows with no bubble
                  pop        = 1'b1;
                  shadow_d   = fifo_head;
                  out_byte_d = head_byte(fifo_head);
                  idx_d      = '0;
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture side: edge detect, FIFO write/drop decision and drop bookkeeping
   always_comb begin
      prev_ce_d    = in_clock_enable;
      strobe       = in_clock_enable && !prev_ce_q;
      // a full FIFO still accepts the write when the serializer pops this edge
      wr_ok        = strobe && (!fifo_full || pop);
      drop         = strobe && fifo_full && !pop;
      wr_rec       = '{cyctype_dir:  in_cyctype_dir,
                       addr:         in_addr[AW_BITS-1:0],
                       data:         in_data,
                       sync_timeout: in_sync_timeout,
                       lost:         lost_q};
      wr_ptr_d     = wr_ptr_q + {{PW{1'b0}}, wr_ok};
      rd_ptr_d     = rd_ptr_q + {{PW{1'b0}}, pop};
      overflow_d   = overflow_q || drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != 8'hFF))
         drop_count_d = drop_count_q + 8'd1;
      lost_d = lost_q;
      if (drop)
         lost_d = 1'b1;
      else if (wr_ok)
         lost_d = 1'b0;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         shadow_q     <= '0;
         out_byte_q   <= 8'h00;
         out_valid_q  <= 1'b0;
         prev_ce_q    <= 1'b1;
         lost_q       <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= 8'h00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         out_byte_q   <= out_byte_d;
         out_valid_q  <= out_valid_d;
         prev_ce_q    <= prev_ce_d;
         lost_q       <= lost_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Record storage; contents are don't-care until written, so no reset
   always_ff @(posedge lpc_clock) begin
      if (wr_ok)
         fifo_mem_q[wr_ptr_q[PW-1:0]] <= wr_rec;
   end

   assign out_byte   = out_byte_q;
   assign out_valid  = out_valid_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lpc_record_framer.sv
// Testbench for lpc_record_framer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based record/byte-stream model.
module tb_lpc_record_framer;

   localparam int DEPTH = 8;
   localparam int AB    = 2;
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
   localparam int NREC  = AB + 3;
`else
   localparam int NREC  = AB + 2;
`endif

   logic        lpc_clock = 1'b0;
   logic        lpc_reset = 1'b0;
   logic [3:0]  in_cyctype_dir = '0;
   logic [31:0] in_addr = '0;
   logic [7:0]  in_data = '0;
   logic        in_sync_timeout = 1'b0;
   logic        in_clock_enable = 1'b1;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
   logic [7:0]  drop_count;

   always #5 lpc_clock = ~lpc_clock;

   lpc_record_framer #(.FIFO_DEPTH(DEPTH), .ADDR_BYTES(AB)) dut (
      .lpc_clock       (lpc_clock),
      .lpc_reset       (lpc_reset),
      .in_cyctype_dir  (in_cyctype_dir),
      .in_addr         (in_addr),
      .in_data         (in_data),
      .in_sync_timeout (in_sync_timeout),
      .in_clock_enable (in_clock_enable),
      .out_byte        (out_byte),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .overflow        (overflow),
      .drop_count      (drop_count)
   );

   typedef struct {
      logic [3:0]  ct;
      logic [31:0] a;
      logic [7:0]  d;
      logic        to;
      logic        lost;
   } mrec_t;

   mrec_t      m_fifo [$];
   logic [7:0] m_cur [$];
   logic [7:0] acc_log [$];
   logic [7:0] exp_log [$];
   bit         m_lost, m_ovf, m_prev_ce;
   int         m_drops;
   int         n_checks = 0;
   int         n_fails  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void load_record(input mrec_t r);
      logic [7:0] x;
      m_cur.delete();
      m_cur.push_back({r.ct, 2'b00, r.lost, r.to});
      for (int i = AB - 1; i >= 0; i--) m_cur.push_back(r.a[8*i +: 8]);
      m_cur.push_back(r.d);
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
      x = 8'h00;
      foreach (m_cur[i]) x = x ^ m_cur[i];
      m_cur.push_back(x);
`else
      x = 8'h00;
`endif
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      m_cur.delete();
      m_lost    = 1'b0;
      m_ovf     = 1'b0;
      m_drops   = 0;
      m_prev_ce = 1'b1;
   endfunction

   // Effect of one rising edge given the inputs presented before it
   function automatic void model_step(input logic ce, input logic [3:0] ct, input logic [31:0] a,
                                      input logic [7:0] d, input logic to, input logic rdy);
      bit strobe, was_full, popped;
      mrec_t r;
      strobe   = ce && !m_prev_ce;
      was_full = (m_fifo.size() == DEPTH);
      popped   = 1'b0;
      if (m_cur.size() == 0) begin
         if (m_fifo.size() > 0) begin
            load_record(m_fifo.pop_front());
            popped = 1'b1;
         end
      end else if (rdy) begin
         void'(m_cur.pop_front());
         if (m_cur.size() == 0 && m_fifo.size() > 0) begin
            load_record(m_fifo.pop_front());
            popped = 1'b1;
         end
      end
      if (strobe) begin
         if (!was_full || popped) begin
            r.ct = ct; r.a = a; r.d = d; r.to = to; r.lost = m_lost;
            m_fifo.push_back(r);
            m_lost = 1'b0;
         end else begin
            m_ovf  = 1'b1;
            if (m_drops < 255) m_drops++;
            m_lost = 1'b1;
         end
      end
      m_prev_ce = ce;
   endfunction

   task automatic check_outputs();
      check("out_valid", out_valid, m_cur.size() != 0);
      if (m_cur.size() != 0) check("out_byte", out_byte, m_cur[0]);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
   endtask

   // One clock: called just after a falling edge, returns after the next one
   task automatic cycle(input logic ce, input logic [3:0] ct, input logic [31:0] a,
                        input logic [7:0] d, input logic to, input logic rdy);
      in_clock_enable = ce;
      in_cyctype_dir  = ct;
      in_addr         = a;
      in_data         = d;
      in_sync_timeout = to;
      out_ready       = rdy;
      if (out_valid && rdy) acc_log.push_back(out_byte);
      model_step(ce, ct, a, d, to, rdy);
      @(negedge lpc_clock);
      check_outputs();
   endtask

   task automatic idle_cycle(input logic ce, input logic rdy);
      cycle(ce, $urandom_range(0, 15), $urandom, $urandom_range(0, 255), 1'b0, rdy);
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_len"}, acc_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++)
         check(tag, acc_log[i], exp_log[i]);
   endtask

   initial begin
      int pct;
      logic ce, rdy;
      model_reset();
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_byte", out_byte, 8'h00);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drop_count", drop_count, 8'h00);
      @(negedge lpc_clock);
      @(negedge lpc_clock);
      lpc_reset = 1'b1;

      // Enable held high across reset release: nothing captured
      repeat (6) idle_cycle(1'b1, 1'b1);

      // Single I/O write
      acc_log.delete();
      exp_log = '{8'h20, 8'h00, 8'h80, 8'h5A};
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
      exp_log.push_back(8'hFA);
`endif
      cycle(1'b0, 4'h2, 32'h0000_0080, 8'h5A, 1'b0, 1'b1);
      cycle(1'b1, 4'h2, 32'h0000_0080, 8'h5A, 1'b0, 1'b1);
      repeat (8) idle_cycle(1'b1, 1'b1);
      compare_log("io_write");

      // Read with timeout, out_ready toggling
      acc_log.delete();
      exp_log = '{8'h01, 8'h03, 8'hF8, 8'h00};
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
      exp_log.push_back(8'hFA);
`endif
      cycle(1'b0, 4'h0, 32'h0000_03F8, 8'h00, 1'b1, 1'b1);
      cycle(1'b1, 4'h0, 32'h0000_03F8, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) idle_cycle(1'b1, 1'(i % 2));
      compare_log("rd_timeout");

      // Overflow: ten strobes with the consumer stalled
      for (int i = 0; i < 10; i++) begin
         idle_cycle(1'b0, 1'b0);
         cycle(1'b1, $urandom_range(0, 15), $urandom, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);
      end
      check("ovf_set", overflow, 1'b1);
      repeat (DEPTH * NREC + 20) idle_cycle(1'b0, 1'b1);

      // First record after a drop carries lost, the next one does not
      acc_log.delete();
      cycle(1'b1, 4'h6, 32'h0000_1111, 8'h22, 1'b0, 1'b1);
      repeat (NREC + 4) idle_cycle(1'b1, 1'b1);
      check("lost_rec_len", acc_log.size(), NREC);
      if (acc_log.size() > 0) check("lost_bit_set", acc_log[0][1], 1'b1);
      acc_log.delete();
      idle_cycle(1'b0, 1'b1);
      cycle(1'b1, 4'h7, 32'h0000_2222, 8'h33, 1'b0, 1'b1);
      repeat (NREC + 4) idle_cycle(1'b1, 1'b1);
      check("clr_rec_len", acc_log.size(), NREC);
      if (acc_log.size() > 0) check("lost_bit_clr", acc_log[0][1], 1'b0);

      // Reset in the middle of a record
      idle_cycle(1'b0, 1'b1);
      cycle(1'b1, 4'hA, 32'h0000_BEEF, 8'h77, 1'b0, 1'b1);
      repeat (3) idle_cycle(1'b1, 1'b1);
      check("mid_rec_valid", out_valid, 1'b1);
      #2 lpc_reset = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_overflow", overflow, 1'b0);
      check("mid_rst_drops", drop_count, 8'h00);
      model_reset();
      @(negedge lpc_clock);
      lpc_reset = 1'b1;
      acc_log.delete();
      exp_log = '{8'h30, 8'h12, 8'h34, 8'hC3};
`ifdef LPC_RECORD_FRAMER_CHECKSUM_EN
      exp_log.push_back(8'hD5);
`endif
      idle_cycle(1'b0, 1'b1);
      cycle(1'b1, 4'h3, 32'h0000_1234, 8'hC3, 1'b0, 1'b1);
      repeat (NREC + 4) idle_cycle(1'b1, 1'b1);
      compare_log("post_rst");

      // Randomized traffic with varying consumer throughput
      pct = 100;
      for (int i = 0; i < 4000; i++) begin
         if (i % 100 == 0) pct = $urandom_range(0, 100);
         ce  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 99) < pct);
         cycle(ce, $urandom_range(0, 15), $urandom, $urandom_range(0, 255), 1'($urandom_range(0, 1)), rdy);
      end
      repeat (DEPTH * NREC * 3) idle_cycle(1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
